mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Parametrised data-memory access unit for the MEM stage. It replaces the single-cycle combinational memory path with a registered bus master: a request handshake with the pipeline, a stall output, byte-lane steering and extension for 8/16/32/64-bit accesses, an internal LL/SC link bit, misalignment detection, a flush path and a bus-timeout watchdog. It sits between the EX/MEM pipeline register and a Wishbone-style classic data bus; MEM/WB consumes its result.

## Interface
- N_DATA, 32, bus/register data width; 32 or 64
- N_ADDR, 32, byte address width
- BIG_ENDIAN, 1, 1: byte offset 0 maps to most-significant lane; 0: to least-significant
- TIMEOUT, 16, bus-wait cycles before forced error; 0 disables the watchdog
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  access request from EX/MEM
- i_we  in  1  1 = store
- i_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when N_DATA=64)
- i_signed  in  1  sign-extend load result
- i_ll / i_sc  in  1 / 1  load-linked / store-conditional qualifiers
- i_addr  in  N_ADDR  byte address
- i_wdata  in  N_DATA  store data, right-aligned
- i_flush  in  1  kill the pending access (exception/branch)
- i_llbit_clr  in  1  clear link bit (ERET)
- o_stall  out  1  hold the pipeline
- o_rvalid  out  1  result valid (one-cycle pulse)
- o_rdata  out  N_DATA  extended load data, SC status, or 0
- o_misalign  out  1  one-cycle misaligned-address pulse
- o_buserr  out  1  one-cycle bus-error or timeout pulse
- o_cyc, o_stb, o_we  out  1 each  bus cycle, strobe, write
- o_sel  out  N_DATA/8  byte-lane enables
- o_addr  out  N_ADDR  bus address, lane-aligned (low log2(N_DATA/8) bits zero)
- o_wdata  out  N_DATA  lane-replicated store data
- i_ack, i_err  in  1 each  bus acknowledge / error
- i_rdata  in  N_DATA  bus read data

## Operation
- FSM states IDLE, BUS, RESP. Reset: IDLE; every output 0; link bit 0; watchdog 0.
- IDLE, i_valid & ~i_flush:
  - Misaligned (half with odd address; word with address[1:0]≠0; dword with address[2:0]≠0; dword when N_DATA=32) → RESP with misalign flag, no bus cycle.
  - SC with link bit 0 → RESP, result 0, no bus cycle, link bit stays 0.
  - Otherwise latch the request, register o_cyc=o_stb=1 with o_we/o_sel/o_addr/o_wdata → BUS.
- Lanes: offset k = address mod (N_DATA/8); lane = BIG_ENDIAN ? N_DATA/8-1-k : k (multi-byte accesses occupy consecutive lanes from there). o_wdata = the size-wide datum replicated across all lanes.
- BUS: hold all bus outputs. i_ack → capture the selected lanes, sign- or zero-extend to N_DATA → RESP. i_err or watchdog==TIMEOUT → RESP with error flag. Any exit from BUS drops o_cyc/o_stb on the next edge.
- RESP: o_rvalid=1 (o_misalign/o_buserr instead when flagged) for exactly one cycle → IDLE. Results: stores 0; SC 1 on success, 0 on failure.
- Link bit: set on successful LL completion; cleared on any executed SC, bus error, or i_llbit_clr. i_llbit_clr wins over a same-cycle set.
- i_flush in BUS: the bus cycle runs to ack/err/timeout (never abandoned), then RESP pulses nothing, and the link bit is not updated. i_flush in IDLE blocks acceptance.

## Timing
- o_stall = (IDLE & i_valid & ~i_flush) | BUS. It is low in RESP, so the pipeline advances on the RESP edge.
- Bus access: accept at cycle 0, o_cyc high cycles 1..n, ack at cycle n ≥ 1, o_rvalid at cycle n+1. Minimum latency is 2 cycles.
- No-bus results (misalign, failed SC): pulse at cycle 1.
- Watchdog counts BUS cycles from 1. With TIMEOUT=T and no ack, o_cyc is high for T cycles.
- ack and err in the same cycle: err wins.
- Reset assertion mid-BUS: o_cyc drops immediately (asynchronously) and no pulse is produced.

## Test plan
- LB, signed, addr 0x1003, BIG_ENDIAN=1, i_rdata=0x112233F4, ack at cycle 1 → o_sel=0001, o_addr=0x1000; o_rvalid at cycle 2 with o_rdata=0xFFFFFFF4; o_stall high cycles 0–1.
- SH, addr 0x2002, i_wdata=0xABCD1234 → o_we=1, o_sel=0011, o_wdata=0x12341234; o_rvalid with o_rdata=0 after ack.
- LW, addr 0x2001 → no o_cyc; o_misalign pulse at cycle 1.
- LL 0x100 (ack), then SC 0x100 → bus write, o_rdata=1. A second SC → no bus cycle, o_rdata=0 at cycle 1. Repeat with i_llbit_clr between LL and SC → SC fails.
- TIMEOUT=4, LW with no ack → o_cyc high exactly 4 cycles, o_buserr pulse, link bit cleared.
- i_flush asserted in BUS, ack 3 cycles later → o_cyc held until ack, no o_rvalid, o_stall drops after ack. N_DATA=64 LD at 0x8 with BIG_ENDIAN=0 → o_sel=0xFF.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-memory access unit: pipeline handshake, byte-lane steering and
// extension, LL/SC link bit, misalignment detection, flush and bus watchdog.
module mem_bus_ctrl #(
  parameter int N_DATA     = 32,
  parameter int N_ADDR     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic                  i_ll,
  input  logic                  i_sc,
  input  logic [N_ADDR-1:0]     i_addr,
  input  logic [N_DATA-1:0]     i_wdata,
  input  logic                  i_flush,
  input  logic                  i_llbit_clr,
  output logic                  o_stall,
  output logic                  o_rvalid,
  output logic [N_DATA-1:0]     o_rdata,
  output logic                  o_misalign,
  output logic                  o_buserr,
  output logic                  o_cyc,
  output logic                  o_stb,
  output logic                  o_we,
  output logic [N_DATA/8-1:0]   o_sel,
  output logic [N_ADDR-1:0]     o_addr,
  output logic [N_DATA-1:0]     o_wdata,
  input  logic                  i_ack,
  input  logic                  i_err,
  input  logic [N_DATA-1:0]     i_rdata
);

  localparam int NB   = N_DATA / 8;
  localparam int OW   = $clog2(NB);
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [NB-1:0]       sel_q, sel_d;
  logic [N_ADDR-1:0]   addr_q, addr_d;
  logic [N_DATA-1:0]   wdata_q, wdata_d;
  logic                rvalid_q, rvalid_d;
  logic                misalign_q, misalign_d;
  logic                buserr_q, buserr_d;
  logic [N_DATA-1:0]   rdata_q, rdata_d;
  logic                link_q, link_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic                ll_q, ll_d;
  logic                sc_q, sc_d;
  logic                kill_q, kill_d;
  logic [OW-1:0]       low_q, low_d;

  int                  k_i, sz_i, low_i, nbits_i;
  logic [NB-1:0]       sel_s;
  logic                misalign_s;
  logic [N_DATA-1:0]   shifted_s, ld_s;
  logic                fill_s, bus_fail_s;

  // Replicates the size-wide store datum across every byte lane.
  function automatic logic [N_DATA-1:0] replicate(input logic [1:0] sz, input logic [N_DATA-1:0] d);
    logic [N_DATA-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      case (sz)
        2'b00:   r[i*8 +: 8] = d[7:0];
        2'b01:   r[i*8 +: 8] = d[(i%2)*8 +: 8];
        2'b10:   r[i*8 +: 8] = d[(i%4)*8 +: 8];
        default: r[i*8 +: 8] = d[i*8 +: 8];
      endcase
    end
    return r;
  endfunction

  // Request decode: lowest occupied lane, lane enables and alignment check.
  always_comb begin
    k_i   = int'(i_addr[OW-1:0]);
    sz_i  = int'(32'd1 << i_size);
    low_i = (BIG_ENDIAN != 0) ? (NB - k_i - sz_i) : k_i;
    sel_s = '0;
    for (int l = 0; l < NB; l++) begin
      sel_s[l] = (l >= low_i) && (l < (low_i + sz_i));
    end
    case (i_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = i_addr[0];
      2'b10:   misalign_s = (i_addr[1:0] != 2'b00);
      default: misalign_s = (N_DATA == 32) || (i_addr[2:0] != 3'b000);
    endcase
  end

  // Load path: shift the captured lanes down and sign- or zero-extend.
  always_comb begin
    shifted_s = i_rdata >> {low_q, 3'b000};
    nbits_i   = int'(32'd8 << size_q);
    nbits_i   = (nbits_i > N_DATA) ? N_DATA : nbits_i;
    fill_s    = 1'b0;
    for (int b = 0; b < N_DATA; b++) begin
      fill_s = (b == (nbits_i - 1)) ? shifted_s[b] : fill_s;
    end
    fill_s = fill_s & sgn_q;
    ld_s   = '0;
    for (int b = 0; b < N_DATA; b++) begin
      ld_s[b] = (b < nbits_i) ? shifted_s[b] : fill_s;
    end
  end

  // Next-state, bus outputs, result pulses and link-bit update.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;
    rdata_d    = '0;
    link_d     = link_q;
    wd_d       = wd_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    ll_d       = ll_q;
    sc_d       = sc_q;
    kill_d     = kill_q;
    low_d      = low_q;
    bus_fail_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          if (misalign_s) begin
            state_d    = S_RESP;
            misalign_d = 1'b1;
          end else if (i_sc && !link_q) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = i_we;
            sel_d   = sel_s;
            addr_d  = {i_addr[N_ADDR-1:OW], {OW{1'b0}}};
            wdata_d = replicate(i_size, i_wdata);
            size_d  = i_size;
            sgn_d   = i_signed;
            ll_d    = i_ll;
            sc_d    = i_sc;
            kill_d  = 1'b0;
            low_d   = low_i[OW-1:0];
            wd_d    = WD_W'(32'd1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        kill_d     = kill_q | i_flush;
        bus_fail_s = i_err || ((TIMEOUT != 0) && (wd_q == WD_MAX));
        if (bus_fail_s || i_ack) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          wd_d    = '0;
          if (kill_d) begin
            link_d = link_q;
          end else if (bus_fail_s) begin
            buserr_d = 1'b1;
            link_d   = 1'b0;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = we_q ? {{(N_DATA-1){1'b0}}, sc_q} : ld_s;
            if (ll_q && !we_q) begin
              link_d = 1'b1;
            end else if (sc_q) begin
              link_d = 1'b0;
            end else begin
              link_d = link_q;
            end
          end
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end else begin
          wd_d = wd_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The explicit clear beats a link set completing in the same cycle.
    if (i_llbit_clr) begin
      link_d = 1'b0;
    end else begin
      link_d = link_d;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      rdata_q    <= '0;
      link_q     <= 1'b0;
      wd_q       <= '0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      ll_q       <= 1'b0;
      sc_q       <= 1'b0;
      kill_q     <= 1'b0;
      low_q      <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
      rdata_q    <= rdata_d;
      link_q     <= link_d;
      wd_q       <= wd_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      ll_q       <= ll_d;
      sc_q       <= sc_d;
      kill_q     <= kill_d;
      low_q      <= low_d;
    end
  end

  assign o_stall    = ((state_q == S_IDLE) && i_valid && !i_flush) || (state_q == S_BUS);
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;
  assign o_misalign = misalign_q;
  assign o_buserr   = buserr_q;
  assign o_cyc      = cyc_q;
  assign o_stb      = cyc_q;
  assign o_we       = we_q;
  assign o_sel      = sel_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: 32-bit big-endian instance (TIMEOUT=4)
// and a 64-bit little-endian instance sharing the control inputs.
module tb_mem_bus_ctrl;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] data;
  } exp_t;

  localparam logic [2:0] RV  = 3'b001;
  localparam logic [2:0] MIS = 3'b010;
  localparam logic [2:0] ERR = 3'b100;

  logic        clk, rst_n;
  logic        i_valid, i_valid64, i_we, i_signed, i_ll, i_sc, i_flush, i_llbit_clr, i_ack, i_err;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic [63:0] i_wdata64, i_rdata64;

  logic        o_stall, o_rvalid, o_misalign, o_buserr, o_cyc, o_stb, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_sel;
  logic        s64, rv64, mis64, err64, cyc64, stb64, we64;
  logic [63:0] rdata64, wdata64;
  logic [31:0] addr64;
  logic [7:0]  sel64;

  int   n_tests, n_fail;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  mem_bus_ctrl #(.N_DATA(32), .N_ADDR(32), .BIG_ENDIAN(1), .TIMEOUT(4)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_we(i_we), .i_size(i_size),
    .i_signed(i_signed), .i_ll(i_ll), .i_sc(i_sc), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_flush(i_flush), .i_llbit_clr(i_llbit_clr), .o_stall(o_stall), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_misalign(o_misalign), .o_buserr(o_buserr), .o_cyc(o_cyc),
    .o_stb(o_stb), .o_we(o_we), .o_sel(o_sel), .o_addr(o_addr), .o_wdata(o_wdata),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata)
  );

  mem_bus_ctrl #(.N_DATA(64), .N_ADDR(32), .BIG_ENDIAN(0), .TIMEOUT(16)) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid64), .i_we(i_we), .i_size(i_size),
    .i_signed(i_signed), .i_ll(i_ll), .i_sc(i_sc), .i_addr(i_addr), .i_wdata(i_wdata64),
    .i_flush(i_flush), .i_llbit_clr(i_llbit_clr), .o_stall(s64), .o_rvalid(rv64),
    .o_rdata(rdata64), .o_misalign(mis64), .o_buserr(err64), .o_cyc(cyc64),
    .o_stb(stb64), .o_we(we64), .o_sel(sel64), .o_addr(addr64), .o_wdata(wdata64),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Response monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (o_rvalid || o_misalign || o_buserr) begin
      if (q32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse32: got %b expected none", {o_buserr, o_misalign, o_rvalid});
      end else begin
        e32 = q32.pop_front();
        chk("resp_kind32", 64'({o_buserr, o_misalign, o_rvalid}), 64'(e32.kind));
        chk("resp_data32", 64'(o_rdata), e32.data);
      end
    end
  end

  // Response monitor for the 64-bit instance.
  always @(negedge clk) begin
    if (rv64 || mis64 || err64) begin
      if (q64.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse64: got %b expected none", {err64, mis64, rv64});
      end else begin
        e64 = q64.pop_front();
        chk("resp_kind64", 64'({err64, mis64, rv64}), 64'(e64.kind));
        chk("resp_data64", rdata64, e64.data);
      end
    end
  end

  // One access on the 32-bit instance; ack_at/flush_at are BUS cycle numbers (0 = never).
  task automatic access(input string nm, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic ll, input logic sc, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic use_err, input int flush_at, input logic [31:0] bus_rdata,
                        input logic exp_bus, input logic [3:0] exp_sel, input logic [31:0] exp_wdata,
                        input int exp_cyc);
    int c;
    @(posedge clk); #1;
    i_valid = 1'b1; i_we = we; i_size = sz; i_signed = sgn; i_ll = ll; i_sc = sc;
    i_addr = addr; i_wdata = wdata;
    @(negedge clk);
    chk({nm, "_stall0"}, 64'(o_stall), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0; i_we = 1'b0; i_ll = 1'b0; i_sc = 1'b0; i_signed = 1'b0;
    if (exp_bus) begin
      c = 1;
      while (c < 40) begin
        if (c == ack_at) begin
          i_ack = ~use_err; i_err = use_err; i_rdata = bus_rdata;
        end
        if (c == flush_at) i_flush = 1'b1;
        @(negedge clk);
        chk({nm, "_stall_bus"}, 64'(o_stall), 64'd1);
        if (c == 1) begin
          chk({nm, "_cyc"}, 64'({o_cyc, o_stb}), 64'd3);
          chk({nm, "_we"}, 64'(o_we), 64'(we));
          chk({nm, "_sel"}, 64'(o_sel), 64'(exp_sel));
          chk({nm, "_addr"}, 64'(o_addr), 64'({addr[31:2], 2'b00}));
          if (we) chk({nm, "_wdata"}, 64'(o_wdata), 64'(exp_wdata));
        end
        @(posedge clk); #1;
        i_ack = 1'b0; i_err = 1'b0; i_flush = 1'b0;
        if (!o_cyc) break;
        c++;
      end
      chk({nm, "_bus_cycles"}, 64'(c), 64'(exp_cyc));
    end
    @(negedge clk);
    chk({nm, "_cyc_resp"}, 64'(o_cyc), 64'd0);
    chk({nm, "_stall_resp"}, 64'(o_stall), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    clk = 1'b0; rst_n = 1'b0;
    i_valid = 1'b0; i_valid64 = 1'b0; i_we = 1'b0; i_size = 2'b00; i_signed = 1'b0;
    i_ll = 1'b0; i_sc = 1'b0; i_flush = 1'b0; i_llbit_clr = 1'b0; i_ack = 1'b0; i_err = 1'b0;
    i_addr = 32'd0; i_wdata = 32'd0; i_rdata = 32'd0; i_wdata64 = 64'd0; i_rdata64 = 64'd0;
    repeat (2) @(negedge clk);
    chk("reset_bus32", 64'({o_cyc, o_stb, o_we, o_sel}), 64'd0);
    chk("reset_resp32", 64'({o_stall, o_rvalid, o_misalign, o_buserr}), 64'd0);
    chk("reset_data32", 64'(o_rdata | o_addr | o_wdata), 64'd0);
    chk("reset_all64", 64'({s64, rv64, mis64, err64, cyc64, stb64, we64, sel64}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LB signed, big-endian offset 3 -> lane 0
    q32.push_back({RV, 64'h0000_0000_FFFF_FFF4});
    access("lb_signed", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h1003, 32'h0, 1, 1'b0, 0,
           32'h1122_33F4, 1'b1, 4'b0001, 32'h0, 1);
    // SH at offset 2 -> lanes 1:0, halfword replicated
    q32.push_back({RV, 64'h0});
    access("sh", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h2002, 32'hABCD_1234, 2, 1'b0, 0,
           32'h0, 1'b1, 4'b0011, 32'h1234_1234, 2);
    // SB offset 1 -> lane 2
    q32.push_back({RV, 64'h0});
    access("sb", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1001, 32'h0000_00A5, 1, 1'b0, 0,
           32'h0, 1'b1, 4'b0100, 32'hA5A5_A5A5, 1);
    // LH unsigned offset 0 -> lanes 3:2
    q32.push_back({RV, 64'h0000_0000_0000_8001});
    access("lhu", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0, 1, 1'b0, 0,
           32'h8001_1234, 1'b1, 4'b1100, 32'h0, 1);
    // LH signed offset 2 -> lanes 1:0
    q32.push_back({RV, 64'h0000_0000_FFFF_F00D});
    access("lhs", 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0002, 32'h0, 3, 1'b0, 0,
           32'h1234_F00D, 1'b1, 4'b0011, 32'h0, 3);
    // misaligned LW
    q32.push_back({MIS, 64'h0});
    access("lw_mis", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h2001, 32'h0, 0, 1'b0, 0,
           32'h0, 1'b0, 4'b0000, 32'h0, 0);
    // LL, SC succeeds, second SC fails
    q32.push_back({RV, 64'h0000_0000_DEAD_BEEF});
    access("ll", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0100, 32'h0, 1, 1'b0, 0,
           32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0, 1);
    q32.push_back({RV, 64'h1});
    access("sc_ok", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0100, 32'h0000_0055, 1, 1'b0, 0,
           32'h0, 1'b1, 4'b1111, 32'h0000_0055, 1);
    q32.push_back({RV, 64'h0});
    access("sc_fail", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0100, 32'h0000_0055, 0, 1'b0, 0,
           32'h0, 1'b0, 4'b0000, 32'h0, 0);
    // LL, link cleared, SC fails
    q32.push_back({RV, 64'h0000_0000_0102_0304});
    access("ll2", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0100, 32'h0, 1, 1'b0, 0,
           32'h0102_0304, 1'b1, 4'b1111, 32'h0, 1);
    @(posedge clk); #1; i_llbit_clr = 1'b1;
    @(posedge clk); #1; i_llbit_clr = 1'b0;
    q32.push_back({RV, 64'h0});
    access("sc_clr", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0100, 32'h0, 0, 1'b0, 0,
           32'h0, 1'b0, 4'b0000, 32'h0, 0);
    // LL, then LW timeout clears link
    q32.push_back({RV, 64'h0000_0000_0000_0007});
    access("ll3", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0100, 32'h0, 2, 1'b0, 0,
           32'h0000_0007, 1'b1, 4'b1111, 32'h0, 2);
    q32.push_back({ERR, 64'h0});
    access("lw_timeout", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0200, 32'h0, 0, 1'b0, 0,
           32'h0, 1'b1, 4'b1111, 32'h0, 4);
    q32.push_back({RV, 64'h0});
    access("sc_after_to", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0100, 32'h0, 0, 1'b0, 0,
           32'h0, 1'b0, 4'b0000, 32'h0, 0);
    // bus error on LB offset 0 -> lane 3
    q32.push_back({ERR, 64'h0});
    access("lb_err", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0000, 32'h0, 2, 1'b1, 0,
           32'h0, 1'b1, 4'b1000, 32'h0, 2);
    // flush in BUS: cycle runs to ack, no response
    access("flush_bus", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0300, 32'h0, 4, 1'b0, 1,
           32'h1234_5678, 1'b1, 4'b1111, 32'h0, 4);
    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    i_valid = 1'b1; i_flush = 1'b1; i_size = 2'b10; i_addr = 32'h0500;
    @(negedge clk);
    chk("flush_idle_stall", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_cyc", 64'(o_cyc), 64'd0);

    // 64-bit LD at 0x8, LB signed at 0x9, misaligned LD at 0x4
    q64.push_back({RV, 64'h8877_6655_4433_2211});
    @(posedge clk); #1;
    i_valid64 = 1'b1; i_we = 1'b0; i_size = 2'b11; i_addr = 32'h8;
    @(posedge clk); #1;
    i_valid64 = 1'b0; i_ack = 1'b1; i_rdata64 = 64'h8877_6655_4433_2211;
    @(negedge clk);
    chk("ld64_cyc", 64'(cyc64), 64'd1);
    chk("ld64_sel", 64'(sel64), 64'hFF);
    chk("ld64_addr", 64'(addr64), 64'h8);
    @(posedge clk); #1;
    i_ack = 1'b0;
    @(negedge clk);
    q64.push_back({RV, 64'hFFFF_FFFF_FFFF_FF92});
    @(posedge clk); #1;
    i_valid64 = 1'b1; i_size = 2'b00; i_signed = 1'b1; i_addr = 32'h9;
    @(posedge clk); #1;
    i_valid64 = 1'b0; i_signed = 1'b0; i_ack = 1'b1; i_rdata64 = 64'h0000_0000_0000_9200;
    @(negedge clk);
    chk("lb64_sel", 64'(sel64), 64'h02);
    @(posedge clk); #1;
    i_ack = 1'b0;
    @(negedge clk);
    q64.push_back({MIS, 64'h0});
    @(posedge clk); #1;
    i_valid64 = 1'b1; i_size = 2'b11; i_addr = 32'h4;
    @(posedge clk); #1;
    i_valid64 = 1'b0;
    @(negedge clk);
    chk("ld64_mis_cyc", 64'(cyc64), 64'd0);

    // reset during BUS drops o_cyc immediately, no pulse
    @(posedge clk); #1;
    i_valid = 1'b1; i_size = 2'b10; i_addr = 32'h0400;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_cyc_before", 64'(o_cyc), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_after", 64'({o_cyc, o_stb, o_stall}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
